// File: rtl/pa_mem_pkg.sv
// Shared encodings and default sizing for the processing-array memory arbiter.
// Owner and read-ID codes are used by the arbiter top and its read-ID FIFO.
package pa_mem_pkg;

    localparam int ADDR_W_DEF    = 32;
    localparam int DATA_W_DEF    = 32;
    localparam int BURST_MAX_DEF = 16;
    localparam int MAX_OUTST_DEF = 4;

    typedef enum logic [1:0] {
        OWN_W = 2'd0,
        OWN_D = 2'd1,
        OWN_O = 2'd2
    } owner_e;

    typedef enum logic {
        RID_W = 1'b0,
        RID_D = 1'b1
    } rid_e;

    // Round-robin successor: W -> D -> O -> W.
    function automatic owner_e next_owner(input owner_e cur);
        case (cur)
            OWN_W:   return OWN_D;
            OWN_D:   return OWN_O;
            default: return OWN_W;
        endcase
    endfunction

endpackage

// File: rtl/pa_rid_fifo.sv
// Small synchronous FIFO of 1-bit read IDs; remembers which requester owns
// each outstanding read so responses can be routed back in issue order.
module pa_rid_fifo
    import pa_mem_pkg::*;
#(
    parameter int DEPTH = MAX_OUTST_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  rid_e                     i_push_id,
    input  logic                     i_pop,
    output rid_e                     o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rid_e             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // NOTE: storage needs no reset; entries are only read once the pointers say they were written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_id;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/pa_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between weight reads (W), data
// reads (D) and result writes (O), with burst bounding and in-order read routing.
module pa_mem_arbiter
    import pa_mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        w_req,
    input  logic [ADDR_W-1:0]           w_addr,
    output logic                        w_ack,
    output logic                        w_rvalid,
    input  logic                        d_req,
    input  logic [ADDR_W-1:0]           d_addr,
    output logic                        d_ack,
    output logic                        d_rvalid,
    input  logic                        o_req,
    input  logic [ADDR_W-1:0]           o_addr,
    input  logic [DATA_W-1:0]           o_wdata,
    output logic                        o_ack,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_gnt,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_rvalid,
    output logic [$clog2(MAX_OUTST):0]  outst_cnt,
    output logic                        err_rsp
);

    localparam int CNT_W = $clog2(MAX_OUTST) + 1;
    localparam int BC_W  = $clog2(BURST_MAX + 1);

    owner_e           r_last_owner;
    logic [BC_W-1:0]  r_burst_cnt;
    logic             r_hold;
    owner_e           r_hold_owner;
    logic             r_err_rsp;

    logic [3:0]       w_elig;
    logic             w_others;
    owner_e           w_sel;
    owner_e           w_cand;
    logic             w_sel_valid;
    logic             w_accept;

    logic             w_fifo_push;
    logic             w_fifo_pop;
    rid_e             w_fifo_push_id;
    rid_e             w_fifo_head;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_full;
    logic             w_fifo_empty;

    // Reads are throttled by the outstanding count; writes never are.
    assign w_elig   = {1'b0, o_req, d_req & ~w_fifo_full, w_req & ~w_fifo_full};
    assign w_others = |(w_elig & ~(4'b0001 << r_last_owner));

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_sel       = OWN_W;
        w_sel_valid = 1'b0;
        w_cand      = r_last_owner;
        if (r_hold && w_elig[r_hold_owner]) begin
            w_sel       = r_hold_owner;
            w_sel_valid = 1'b1;
        end else if ((r_burst_cnt != '0) && w_elig[r_last_owner] &&
                     ((r_burst_cnt < BC_W'(BURST_MAX)) || !w_others)) begin
            w_sel       = r_last_owner;
            w_sel_valid = 1'b1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                w_cand = next_owner(w_cand);
                if (!w_sel_valid && w_elig[w_cand]) begin
                    w_sel       = w_cand;
                    w_sel_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (w_sel)
            OWN_W:   mem_addr = w_addr;
            OWN_D:   mem_addr = d_addr;
            default: mem_addr = o_addr;
        endcase
    end

    assign mem_req   = rst_n & w_sel_valid;
    assign mem_we    = (w_sel == OWN_O);
    assign mem_wdata = o_wdata;
    assign w_accept  = mem_req & mem_gnt;

    assign w_ack = w_accept & (w_sel == OWN_W);
    assign d_ack = w_accept & (w_sel == OWN_D);
    assign o_ack = w_accept & (w_sel == OWN_O);

    assign w_fifo_push    = w_accept & (w_sel != OWN_O);
    assign w_fifo_push_id = (w_sel == OWN_D) ? RID_D : RID_W;
    assign w_fifo_pop     = mem_rvalid & ~w_fifo_empty;

    pa_rid_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_rid_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_fifo_push),
        .i_push_id (w_fifo_push_id),
        .i_pop     (w_fifo_pop),
        .o_head    (w_fifo_head),
        .o_count   (w_fifo_count),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    assign rdata     = mem_rdata;
    assign w_rvalid  = rst_n & w_fifo_pop & (w_fifo_head == RID_W);
    assign d_rvalid  = rst_n & w_fifo_pop & (w_fifo_head == RID_D);
    assign outst_cnt = w_fifo_count;
    assign err_rsp   = r_err_rsp;

    // A refused request locks its owner for the next cycle so the port stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_owner <= OWN_O;
            r_burst_cnt  <= '0;
            r_hold       <= 1'b0;
            r_hold_owner <= OWN_O;
            r_err_rsp    <= 1'b0;
        end else begin
            r_hold       <= mem_req & ~mem_gnt;
            r_hold_owner <= w_sel;
            if (mem_rvalid && w_fifo_empty) begin
                r_err_rsp <= 1'b1;
            end
            if (w_accept) begin
                if (w_sel == r_last_owner) begin
                    if (r_burst_cnt < BC_W'(BURST_MAX)) begin
                        r_burst_cnt <= r_burst_cnt + BC_W'(1);
                    end
                end else begin
                    r_burst_cnt  <= BC_W'(1);
                    r_last_owner <= w_sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_pa_mem_arbiter.sv
// Self-checking bench for pa_mem_arbiter: directed scenarios plus a randomized
// phase, all compared against a queue-based model of the arbitration rules.
module tb_pa_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BMAX = 4;
    localparam int MOUT = 4;
    localparam int CW   = $clog2(MOUT) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          w_req = 1'b0;
    logic [AW-1:0] w_addr = '0;
    logic          w_ack;
    logic          w_rvalid;
    logic          d_req = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic          d_ack;
    logic          d_rvalid;
    logic          o_req = 1'b0;
    logic [AW-1:0] o_addr = '0;
    logic [DW-1:0] o_wdata = '0;
    logic          o_ack;
    logic [DW-1:0] rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt = 1'b1;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rvalid = 1'b0;
    logic [CW-1:0] outst_cnt;
    logic          err_rsp;

    always #5 clk = ~clk;

    pa_mem_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .BURST_MAX (BMAX),
        .MAX_OUTST (MOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .w_req      (w_req),
        .w_addr     (w_addr),
        .w_ack      (w_ack),
        .w_rvalid   (w_rvalid),
        .d_req      (d_req),
        .d_addr     (d_addr),
        .d_ack      (d_ack),
        .d_rvalid   (d_rvalid),
        .o_req      (o_req),
        .o_addr     (o_addr),
        .o_wdata    (o_wdata),
        .o_ack      (o_ack),
        .rdata      (rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .outst_cnt  (outst_cnt),
        .err_rsp    (err_rsp)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: owner history, outstanding read IDs (0=W, 1=D), error flag.
    int m_last;
    int m_run;
    int m_q[$];
    bit m_err;
    bit m_hold;
    int m_hold_own;

    bit [2:0]      e_ack;
    bit [2:0]      obs_ack;
    bit [1:0]      obs_rv;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_last = 2;
        m_run  = 0;
        m_q.delete();
        m_err  = 1'b0;
        m_hold = 1'b0;
        m_hold_own = 0;
    endtask

    // One clock cycle: predict and compare at the falling edge, then advance the model.
    task automatic step(input string tag);
        bit el[3];
        int own;
        bit others;
        bit acc;
        bit pop;
        logic [AW-1:0] exp_addr;
        @(negedge clk);
        el[0] = w_req && (m_q.size() < MOUT);
        el[1] = d_req && (m_q.size() < MOUT);
        el[2] = o_req;
        own = -1;
        if (m_hold && el[m_hold_own]) own = m_hold_own;
        if (own < 0 && m_run > 0 && el[m_last]) begin
            others = 1'b0;
            for (int k = 0; k < 3; k++) if (k != m_last && el[k]) others = 1'b1;
            if (m_run < BMAX || !others) own = m_last;
        end
        if (own < 0) begin
            for (int k = 1; k <= 3; k++) begin
                if (own < 0 && el[(m_last + k) % 3]) own = (m_last + k) % 3;
            end
        end
        acc = (own >= 0) && mem_gnt;
        pop = mem_rvalid && (m_q.size() > 0);
        e_ack = acc ? (3'b001 << own) : 3'b000;

        check({tag, " mem_req"}, 64'(mem_req), 64'(own >= 0));
        if (own >= 0) begin
            exp_addr = (own == 0) ? w_addr : (own == 1) ? d_addr : o_addr;
            check({tag, " mem_addr"}, 64'(mem_addr), 64'(exp_addr));
            check({tag, " mem_we"}, 64'(mem_we), 64'(own == 2));
            if (own == 2) check({tag, " mem_wdata"}, 64'(mem_wdata), 64'(o_wdata));
        end
        check({tag, " acks"}, 64'({o_ack, d_ack, w_ack}), 64'(e_ack));
        check({tag, " w_rvalid"}, 64'(w_rvalid), 64'(pop && m_q[0] == 0));
        check({tag, " d_rvalid"}, 64'(d_rvalid), 64'(pop && m_q[0] == 1));
        if (mem_rvalid) check({tag, " rdata"}, 64'(rdata), 64'(mem_rdata));
        check({tag, " outst_cnt"}, 64'(outst_cnt), 64'(m_q.size()));
        check({tag, " err_rsp"}, 64'(err_rsp), 64'(m_err));

        obs_ack   = {o_ack, d_ack, w_ack};
        obs_rv    = {d_rvalid, w_rvalid};
        obs_addr  = mem_addr;
        obs_rdata = rdata;

        if (mem_rvalid) begin
            if (pop) void'(m_q.pop_front());
            else     m_err = 1'b1;
        end
        if (acc) begin
            if (own == m_last) begin
                if (m_run < BMAX) m_run++;
            end else begin
                m_run  = 1;
                m_last = own;
            end
            if (own != 2) m_q.push_back(own);
        end
        m_hold     = (own >= 0) && !mem_gnt;
        m_hold_own = (own >= 0) ? own : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic step_drain(input string tag);
        mem_rvalid = (m_q.size() > 0);
        mem_rdata  = $urandom;
        step(tag);
        mem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst mem_req", 64'(mem_req), 64'(0));
        check("rst acks", 64'({o_ack, d_ack, w_ack}), 64'(0));
        check("rst rvalids", 64'({d_rvalid, w_rvalid}), 64'(0));
        check("rst outst_cnt", 64'(outst_cnt), 64'(0));
        check("rst err_rsp", 64'(err_rsp), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        w_req = 1'b0;
        d_req = 1'b0;
        o_req = 1'b0;
        mem_gnt = 1'b1;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        int seq[4] = '{0, 1, 1, 0};
        model_reset();
        @(posedge clk);
        #1;

        // Reset with every requester and a response active: outputs forced low.
        w_req = 1'b1; d_req = 1'b1; o_req = 1'b1; mem_rvalid = 1'b1;
        do_reset();
        idle_inputs();

        // Single read, response two cycles after acceptance.
        w_req = 1'b1; w_addr = 32'h100;
        step("single issue");
        check("single w_ack", 64'(obs_ack), 64'(3'b001));
        check("single addr", 64'(obs_addr), 64'(32'h100));
        w_req = 1'b0;
        check("single outst", 64'(outst_cnt), 64'(1));
        step("single gap");
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
        step("single rsp");
        check("single rvalid", 64'(obs_rv), 64'(2'b01));
        check("single rdata", 64'(obs_rdata), 64'(32'hDEAD));
        mem_rvalid = 1'b0;
        check("single drained", 64'(outst_cnt), 64'(0));

        // Fairness: all three requesting, bursts of BMAX each in rotation.
        do_reset();
        idle_inputs();
        w_req = 1'b1; d_req = 1'b1; o_req = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step_drain("fair");
            check("fair owner", 64'(obs_ack), 64'(3'b001 << ((i / 4) % 3)));
            if (e_ack[0]) w_addr = $urandom;
            if (e_ack[1]) d_addr = $urandom;
            if (e_ack[2]) begin o_addr = $urandom; o_wdata = $urandom; end
        end
        w_req = 1'b0; o_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_drain("d only");
            check("d only ack", 64'(obs_ack), 64'(3'b010));
        end
        d_req = 1'b0;

        // Outstanding limit: W blocked after MOUT reads, writes continue.
        do_reset();
        idle_inputs();
        w_req = 1'b1; o_req = 1'b1; w_addr = 32'h400; o_addr = 32'h800; o_wdata = 32'h5A5A;
        for (int i = 0; i < 8; i++) begin
            step("limit");
            check("limit owner", 64'(obs_ack), 64'((i < 4) ? 3'b001 : 3'b100));
        end
        check("limit outst", 64'(outst_cnt), 64'(MOUT));
        mem_rvalid = 1'b1; mem_rdata = 32'h11;
        step("limit pop");
        check("limit no bypass", 64'(obs_ack), 64'(3'b100));
        mem_rvalid = 1'b0;
        step("limit resume");
        check("limit w resumes", 64'(obs_ack), 64'(3'b001));
        w_req = 1'b0; o_req = 1'b0;
        for (int k = 0; k < 8 && m_q.size() > 0; k++) step_drain("limit drain");
        check("limit drained", 64'(outst_cnt), 64'(0));

        // Routing order W,D,D,W.
        do_reset();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            w_req = (seq[k] == 0); d_req = (seq[k] == 1);
            w_addr = 32'h1000 + 32'(k); d_addr = 32'h2000 + 32'(k);
            step("route issue");
            check("route ack", 64'(obs_ack), 64'(seq[k] == 0 ? 3'b001 : 3'b010));
        end
        w_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'(k + 1);
            step("route rsp");
            check("route rvalid", 64'(obs_rv), 64'(seq[k] == 0 ? 2'b01 : 2'b10));
            check("route rdata", 64'(obs_rdata), 64'(k + 1));
        end
        mem_rvalid = 1'b0;

        // Stall with D owning: port stable, burst count frozen.
        do_reset();
        idle_inputs();
        d_req = 1'b1; d_addr = 32'h200;
        step_drain("stall pre");
        check("stall pre d", 64'(obs_ack), 64'(3'b010));
        d_addr = 32'h208;
        step_drain("stall pre");
        check("stall pre d2", 64'(obs_ack), 64'(3'b010));
        d_addr = 32'h210; w_req = 1'b1; w_addr = 32'h300; mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_drain("stall");
            check("stall no ack", 64'(obs_ack), 64'(0));
            check("stall addr", 64'(obs_addr), 64'(32'h210));
        end
        mem_gnt = 1'b1;
        step_drain("stall post");
        check("stall post d3", 64'(obs_ack), 64'(3'b010));
        d_addr = 32'h218;
        step_drain("stall post");
        check("stall post d4", 64'(obs_ack), 64'(3'b010));
        step_drain("stall post");
        check("stall switch w", 64'(obs_ack), 64'(3'b001));
        idle_inputs();
        for (int k = 0; k < 8 && m_q.size() > 0; k++) step_drain("stall drain");

        // Response with nothing outstanding sets the sticky error.
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
        step("err rsp");
        check("err no rvalid", 64'(obs_rv), 64'(0));
        check("err set", 64'(err_rsp), 64'(1));
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) step("err hold");
        check("err sticky", 64'(err_rsp), 64'(1));

        // Reset mid-burst with three reads outstanding.
        do_reset();
        idle_inputs();
        w_req = 1'b1; w_addr = 32'h40;
        for (int i = 0; i < 3; i++) step("midrst issue");
        check("midrst outst", 64'(outst_cnt), 64'(3));
        o_req = 1'b1;
        do_reset();
        step("midrst first");
        check("midrst w first", 64'(obs_ack), 64'(3'b001));
        idle_inputs();

        // Randomized traffic against the model.
        do_reset();
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            if (!w_req && $urandom_range(2) == 0) begin w_req = 1'b1; w_addr = $urandom; end
            if (!d_req && $urandom_range(2) == 0) begin d_req = 1'b1; d_addr = $urandom; end
            if (!o_req && $urandom_range(2) == 0) begin
                o_req = 1'b1; o_addr = $urandom; o_wdata = $urandom;
            end
            mem_gnt    = ($urandom_range(3) != 0);
            mem_rvalid = (m_q.size() > 0) && ($urandom_range(1) == 1);
            mem_rdata  = $urandom;
            step("rnd");
            if (e_ack[0]) w_req = 1'b0;
            if (e_ack[1]) d_req = 1'b0;
            if (e_ack[2]) o_req = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pa_mem_arbiter.md
Name: pa_mem_arbiter

Overview:
- Shares the single external memory port between the three processing-array traffic classes: weight read (W), input-data read (D) and destination/result write (O).
- Sits between the PA sequencing state machine and the memory interface.
- Round-robin arbitration with bounded bursts, read-outstanding limiting, and in-order routing of read responses back to the requester that issued them.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width
BURST_MAX, 16, maximum consecutive accepted beats per owner while others wait
MAX_OUTST, 4, maximum reads issued and not yet returned (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
w_req  in  1  weight read request
w_addr  in  ADDR_W  weight read address
w_ack  out  1  weight request accepted this cycle
w_rvalid  out  1  weight read data valid
d_req  in  1  data read request
d_addr  in  ADDR_W  data read address
d_ack  out  1  data request accepted this cycle
d_rvalid  out  1  data read data valid
o_req  in  1  result write request
o_addr  in  ADDR_W  result write address
o_wdata  in  DATA_W  result write data
o_ack  out  1  write accepted this cycle
rdata  out  DATA_W  read data, broadcast to W and D
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_gnt  in  1  memory accepts the request this cycle
mem_rdata  in  DATA_W  memory read data
mem_rvalid  in  1  memory read data valid (in issue order)
outst_cnt  out  $clog2(MAX_OUTST)+1  reads outstanding
err_rsp  out  1  sticky: response received with none outstanding

Behaviour:
- Reset values while rst_n=0:
  - Registers: last_owner=O, burst_cnt=0, ID FIFO empty, outst_cnt=0, err_rsp=0.
  - Outputs: mem_req, all acks and all rvalids forced 0 combinationally.
- Eligibility:
  - W and D are eligible when requesting and outst_cnt<MAX_OUTST. There is no same-cycle bypass from a popping response.
  - O is eligible whenever o_req=1.
- Owner selection (combinational, each cycle):
  - Keep the current owner if it is eligible and either burst_cnt<BURST_MAX or no other requester is eligible.
  - Otherwise pick the next eligible requester in rotation W→D→O→W, starting after last_owner.
  - If nothing is eligible, mem_req=0.
- Issue:
  - mem_req=1 with the selected requester's address, mem_we=(owner==O), and mem_wdata=o_wdata.
  - Beat accepted iff mem_req&mem_gnt. The owner's ack equals acceptance in the same cycle (zero-latency handshake).
  - The requester holds req and addr until acked.
- Stall (mem_gnt=0): mem_addr/mem_we stay stable, the owner is held, burst_cnt is unchanged.
- Burst counter, on accepted beat:
  - Same owner as last_owner: burst_cnt = min(burst_cnt+1, BURST_MAX).
  - Different owner: burst_cnt=1 and last_owner=owner.
- ID FIFO (depth MAX_OUTST, 1-bit ID, 0=W, 1=D):
  - Push on accepted read; pop on mem_rvalid.
  - Push and pop in the same cycle leave outst_cnt unchanged.
- Response routing:
  - rdata=mem_rdata, passed through combinationally.
  - w_rvalid=mem_rvalid & fifo_not_empty & head==W; d_rvalid likewise for head==D.
  - Read latency is whatever the memory provides; the block adds none.
- mem_rvalid with an empty FIFO: data dropped, no rvalid, err_rsp set. err_rsp is cleared only by reset.
- Writes do not enter the FIFO and can be issued while reads are outstanding; the memory keeps order.
- Reset mid-operation clears outstanding tracking immediately. The memory is reset by the same rst_n.

Decomposition:
- Package pa_mem_pkg:
  - owner encoding (OWN_W=0, OWN_D=1, OWN_O=2).
  - read-ID encoding (RID_W=0, RID_D=1).
  - default parameter constants.
- Sub-module pa_rid_fifo: synchronous 1-bit FIFO with push, pop, head, count, full and empty.
- Arbitration and burst logic stay in the top module.

Test Plan:
- Single read: after reset, w_req=1, w_addr=0x100, mem_gnt=1 → mem_addr=0x100, mem_we=0, w_ack=1 in the same cycle, outst_cnt=1. mem_rvalid=1 with mem_rdata=0xDEAD two cycles later → w_rvalid=1, rdata=0xDEAD, d_rvalid=0, outst_cnt=0.
- Fairness: BURST_MAX=4, mem_gnt=1, memory returns reads every cycle, all three requesting continuously → accepted owners W×4, D×4, O×4, W×4… If only D requests, D is granted every cycle indefinitely.
- Outstanding limit: MAX_OUTST=4, mem_rvalid=0, w_req and o_req held → 4 W beats accepted, then W blocked while O writes proceed every cycle. One mem_rvalid → W accepted on the next cycle.
- Routing order: accepted reads W,D,D,W, then four responses 0x1,0x2,0x3,0x4 → w_rvalid on 0x1 and 0x4, d_rvalid on 0x2 and 0x3.
- Stall and error:
  - mem_gnt=0 for 3 cycles with D owning → mem_addr stable, no d_ack, burst_cnt unchanged.
  - mem_rvalid with outst_cnt=0 → err_rsp=1, which stays set until rst_n=0.
- Reset mid-burst: 3 reads outstanding, rst_n pulsed low → outst_cnt=0 and mem_req=0 immediately. After release, last_owner=O, so W is granted first.
